// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake and flush.
// Define EXMEM_SKID_EN to add a second skid entry and register ready_e.
module exmem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_e,
  output logic                  ready_e,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [DATA_W-1:0]     ALUResultE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [DATA_W-1:0]     PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RdE,
  output logic                  valid_m,
  input  logic                  ready_m,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [DATA_W-1:0]     ALUResultM,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic [DATA_W-1:0]     PCPlus4M,
  output logic [1:0]            occ_o
);

  typedef struct packed {
    logic                  rw;
    logic                  mw;
    logic [1:0]            rs;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] rd;
  } bundle_t;

  bundle_t in_b;
  bundle_t main_q;
  logic    vld_q;

  assign in_b = '{rw: RegWriteE, mw: MemWriteE,
                  rs: ResultSrcE, alu: ALUResultE,
                  wd: WriteDataE, pc: PCPlus4E,
                  rd: RdE};

  assign valid_m    = vld_q;
  assign RegWriteM  = main_q.rw;
  assign MemWriteM  = main_q.mw;
  assign ResultSrcM = main_q.rs;
  assign ALUResultM = main_q.alu;
  assign WriteDataM = main_q.wd;
  assign RdM        = main_q.rd;
  assign PCPlus4M   = main_q.pc;

`ifdef EXMEM_SKID_EN

  bundle_t skid_q;
  logic    skid_vq;

  // skid only fills while main is held, so skid valid implies main valid
  assign ready_e = ~skid_vq;
  assign occ_o   = {skid_vq, vld_q & ~skid_vq};

  // main/skid update: skid drains first, bubbles keep data but drop control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      skid_vq <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      vld_q     <= 1'b0;
      skid_vq   <= 1'b0;
      main_q.rw <= 1'b0;
      main_q.mw <= 1'b0;
      main_q.rs <= '0;
      skid_q.rw <= 1'b0;
      skid_q.mw <= 1'b0;
      skid_q.rs <= '0;
    end else if (skid_vq) begin
      if (ready_m) begin
        main_q  <= skid_q;
        skid_vq <= 1'b0;
      end
    end else if (!vld_q || ready_m) begin
      vld_q <= valid_e;
      if (valid_e) begin
        main_q <= in_b;
      end else begin
        main_q.rw <= 1'b0;
        main_q.mw <= 1'b0;
        main_q.rs <= '0;
      end
    end else if (valid_e) begin
      skid_q  <= in_b;
      skid_vq <= 1'b1;
    end
  end

`else

  assign ready_e = ready_m | ~vld_q;
  assign occ_o   = {1'b0, vld_q};

  // single entry: load on accept, bubbles keep data but drop control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      main_q <= '0;
    end else if (flush_i) begin
      vld_q     <= 1'b0;
      main_q.rw <= 1'b0;
      main_q.mw <= 1'b0;
      main_q.rs <= '0;
    end else if (ready_e) begin
      vld_q <= valid_e;
      if (valid_e) begin
        main_q <= in_b;
      end else begin
        main_q.rw <= 1'b0;
        main_q.mw <= 1'b0;
        main_q.rs <= '0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboarded directed bench for exmem_pipe_reg.
// Honours EXMEM_SKID_EN for the mode-specific stall sequence.
module tb_exmem_pipe_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          rw;
    logic          mw;
    logic [1:0]    rs;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [DW-1:0] pc;
    logic [RW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, valid_e, ready_m;
  logic          ready_e, valid_m;
  logic          RegWriteE, MemWriteE;
  logic [1:0]    ResultSrcE;
  logic [DW-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [RW-1:0] RdE;
  logic          RegWriteM, MemWriteM;
  logic [1:0]    ResultSrcM;
  logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [RW-1:0] RdM;
  logic [1:0]    occ_o;

  int applied    = 0;
  int miscompares = 0;
  exp_t sb[$];

  exmem_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .valid_e(valid_e), .ready_e(ready_e),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .valid_m(valid_m), .ready_m(ready_m),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .occ_o(occ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] tag, input logic mw);
    exp_t b;
    b.rw  = 1'b1;
    b.mw  = mw;
    b.rs  = tag[5:4];
    b.alu = tag;
    b.wd  = tag ^ 32'hA5A5_0000;
    b.pc  = 32'h0000_1000 + (tag << 2);
    b.rd  = tag[4:0] ^ 5'h1F;
    return b;
  endfunction

  task automatic drive(input exp_t b, input logic v);
    valid_e    = v;
    RegWriteE  = b.rw;
    MemWriteE  = b.mw;
    ResultSrcE = b.rs;
    ALUResultE = b.alu;
    WriteDataE = b.wd;
    PCPlus4E   = b.pc;
    RdE        = b.rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // output transfer monitor: compare the bundle leaving at the next edge
  always @(negedge clk) begin
    if (rst_n && !flush_i && valid_m && ready_m) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {32'h0, ALUResultM}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_rw",  {63'h0, RegWriteM}, {63'h0, e.rw});
        chk("out_mw",  {63'h0, MemWriteM}, {63'h0, e.mw});
        chk("out_rs",  {62'h0, ResultSrcM}, {62'h0, e.rs});
        chk("out_alu", {32'h0, ALUResultM}, {32'h0, e.alu});
        chk("out_wd",  {32'h0, WriteDataM}, {32'h0, e.wd});
        chk("out_pc",  {32'h0, PCPlus4M}, {32'h0, e.pc});
        chk("out_rd",  {59'h0, RdM}, {59'h0, e.rd});
      end
    end
  end

  exp_t a, b, c;

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    ready_m = 1'b1;
    drive(mk(32'h55, 1'b1), 1'b1);

    // reset with a live EX bundle
    tick;
    tick;
    chk("rst_valid", {63'h0, valid_m}, 64'h0);
    chk("rst_regw", {63'h0, RegWriteM}, 64'h0);
    chk("rst_occ", {62'h0, occ_o}, 64'h0);
    chk("rst_alu", {32'h0, ALUResultM}, 64'h0);
    valid_e = 1'b0;
    rst_n   = 1'b1;
    tick;
    chk("rel_ready", {63'h0, ready_e}, 64'h1);
    chk("rel_valid", {63'h0, valid_m}, 64'h0);

    // streaming 0x10, 0x20, 0x30
    for (int i = 1; i <= 3; i++) begin
      a = mk(32'(i * 16), 1'b0);
      drive(a, 1'b1);
      sb.push_back(a);
      tick;
      chk("strm_valid", {63'h0, valid_m}, 64'h1);
      chk("strm_alu", {32'h0, ALUResultM}, {32'h0, a.alu});
    end
    valid_e = 1'b0;
    tick;
    chk("bub_valid", {63'h0, valid_m}, 64'h0);
    chk("bub_regw", {63'h0, RegWriteM}, 64'h0);
    chk("bub_alu_hold", {32'h0, ALUResultM}, 64'h30);

    // stall with A held, B waiting
    a = mk(32'h41, 1'b1);
    b = mk(32'h42, 1'b0);
    ready_m = 1'b0;
    drive(a, 1'b1);
    sb.push_back(a);
    tick;
`ifdef EXMEM_SKID_EN
    drive(b, 1'b1);
    sb.push_back(b);
    chk("sk_ready1", {63'h0, ready_e}, 64'h1);
    chk("sk_occ1", {62'h0, occ_o}, 64'h1);
    tick;
    valid_e = 1'b0;
    chk("sk_occ2", {62'h0, occ_o}, 64'h2);
    chk("sk_ready0", {63'h0, ready_e}, 64'h0);
    chk("sk_alu_a", {32'h0, ALUResultM}, {32'h0, a.alu});
    tick;
    chk("sk_stall_alu", {32'h0, ALUResultM}, {32'h0, a.alu});
    ready_m = 1'b1;
    tick;
    chk("sk_alu_b", {32'h0, ALUResultM}, {32'h0, b.alu});
    chk("sk_occ_b", {62'h0, occ_o}, 64'h1);
    chk("sk_ready_b", {63'h0, ready_e}, 64'h1);
    tick;
`else
    drive(b, 1'b1);
    sb.push_back(b);
    for (int i = 0; i < 3; i++) begin
      chk("st_ready", {63'h0, ready_e}, 64'h0);
      chk("st_valid", {63'h0, valid_m}, 64'h1);
      chk("st_alu", {32'h0, ALUResultM}, {32'h0, a.alu});
      chk("st_occ", {62'h0, occ_o}, 64'h1);
      tick;
    end
    ready_m = 1'b1;
    #1;
    chk("st_ready_rel", {63'h0, ready_e}, 64'h1);
    tick;
    valid_e = 1'b0;
    chk("st_alu_b", {32'h0, ALUResultM}, {32'h0, b.alu});
    tick;
`endif
    chk("st_drain", {63'h0, valid_m}, 64'h0);

    // flush mid-stall, C presented in flush cycle
    a = mk(32'h61, 1'b1);
    b = mk(32'h62, 1'b1);
    c = mk(32'h63, 1'b1);
    ready_m = 1'b0;
    drive(a, 1'b1);
    tick;
`ifdef EXMEM_SKID_EN
    drive(b, 1'b1);
    tick;
    chk("fl_occ2", {62'h0, occ_o}, 64'h2);
`endif
    drive(c, 1'b1);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    valid_e = 1'b0;
    chk("fl_valid", {63'h0, valid_m}, 64'h0);
    chk("fl_memw", {63'h0, MemWriteM}, 64'h0);
    chk("fl_regw", {63'h0, RegWriteM}, 64'h0);
    chk("fl_rs", {62'h0, ResultSrcM}, 64'h0);
    chk("fl_occ", {62'h0, occ_o}, 64'h0);
    chk("fl_alu_hold", {32'h0, ALUResultM}, {32'h0, a.alu});
    ready_m = 1'b1;
    tick;
    chk("fl_c_dropped", {63'h0, valid_m}, 64'h0);

    // flush with stage empty and ready_e high still drops the bundle
    drive(c, 1'b1);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    valid_e = 1'b0;
    chk("fl2_valid", {63'h0, valid_m}, 64'h0);
    chk("fl2_occ", {62'h0, occ_o}, 64'h0);

    // reset during stall
    ready_m = 1'b0;
    drive(a, 1'b1);
    tick;
`ifdef EXMEM_SKID_EN
    drive(b, 1'b1);
    tick;
    chk("rs_occ2", {62'h0, occ_o}, 64'h2);
`endif
    valid_e = 1'b0;
    rst_n   = 1'b0;
    tick;
    chk("rs_valid", {63'h0, valid_m}, 64'h0);
    chk("rs_occ", {62'h0, occ_o}, 64'h0);
    chk("rs_ctrl", {60'h0, RegWriteM, MemWriteM, ResultSrcM}, 64'h0);
    chk("rs_alu", {32'h0, ALUResultM}, 64'h0);
    chk("rs_wd", {32'h0, WriteDataM}, 64'h0);
    chk("rs_pc", {32'h0, PCPlus4M}, 64'h0);
    chk("rs_rd", {59'h0, RdM}, 64'h0);
    rst_n   = 1'b1;
    ready_m = 1'b1;
    tick;
    chk("rs_lost", {63'h0, valid_m}, 64'h0);
    chk("rs_ready", {63'h0, ready_e}, 64'h1);

    tick;
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule

// File: doc/exmem_pipe_reg.md
# exmem_pipe_reg

Parametrised EX/MEM pipeline stage register for the RISC-V pipeline, sitting between the execute stage (ALU, branch unit) and the memory-access stage. It carries the EX-stage control and data bundle through a valid/ready elastic handshake, so the memory stage can back-pressure execute. It also supports a synchronous flush that inserts a bubble. An optional compile-time skid entry gives registered back-pressure and full throughput under stall.

## Interface
Parameters:
- DATA_W, 32, width of ALUResult, WriteData, PCPlus4
- REG_ADDR_W, 5, width of destination register index Rd

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- flush_i  input  1  synchronous bubble-insert request; kills all held entries
- valid_e  input  1  EX bundle valid
- ready_e  output  1  stage can accept the EX bundle this cycle
- RegWriteE, MemWriteE  input  1 each  EX control bits
- ResultSrcE  input  2  EX writeback source select
- ALUResultE, WriteDataE, PCPlus4E  input  DATA_W each  EX data
- RdE  input  REG_ADDR_W  EX destination register
- valid_m  output  1  MEM bundle valid
- ready_m  input  1  MEM stage accepts the bundle this cycle
- RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M  output  widths as EX counterparts
- occ_o  output  2  entries held (0..1 base, 0..2 with skid)

## Operation
- Transfer in: valid_e & ready_e at the clock edge. Transfer out: valid_m & ready_m at the clock edge.
- Priority at each edge: reset > flush > normal update.
- Reset (rst_n=0 at edge): valid_m=0, occ_o=0, and every M output is 0. ready_e is 1 the cycle after reset.
- Flush (flush_i=1, rst_n=1): all entries are invalidated and occ_o becomes 0.
  - RegWriteM, MemWriteM and ResultSrcM become 0.
  - The data outputs (ALUResultM, WriteDataM, RdM, PCPlus4M) hold their values.
  - An EX bundle presented in the flush cycle is discarded, even if ready_e=1.
- Invariant: valid_m=0 implies RegWriteM=0 and MemWriteM=0, so no architectural side effect ever comes from a bubble.
- Base mode (no skid):
  - ready_e = ready_m | ~valid_m (combinational).
  - When ready_e is high, valid_m takes valid_e at the edge.
  - If valid_e=1, all fields load. If valid_e=0, the control outputs are zeroed and data holds.
  - When ready_e is low, all outputs hold.
- Widths: all fields are passed bit-exact; there is no truncation. ALUResult is DATA_W wide, not address width.

## Timing
- Latency: a bundle accepted at edge N is visible on the M outputs after edge N; it is 1 cycle in both modes.
- Throughput: 1 bundle per cycle while ready_m=1.
- Base mode: ready_e has a combinational path from ready_m.
- Skid mode: ready_e is registered, with no combinational ready_m→ready_e path.
- A simultaneous in and out transfer with occ_o=1 keeps occ_o=1 and replaces the output with the new bundle.
- Stall (ready_m=0 with valid_m=1): all M outputs are stable until the transfer out.

## Configuration
- Macro EXMEM_SKID_EN.
  - Undefined: base single-entry behaviour as above. occ_o max is 1.
- Defined: a second skid entry behind the main entry.
  - ready_e = ~skid_valid (registered).
  - If main is held, ready_m=0, and a transfer in occurs, the bundle is written to skid. occ_o becomes 2 and ready_e drops after that edge.
  - When ready_m=1 with skid full, skid moves to main at the edge and ready_e rises after it.
  - If main is empty, incoming bundles always go to main.
  - Ordering is strictly FIFO.
  - Flush clears both entries.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with valid_e=1 and RegWriteE=1. Required: valid_m=0, RegWriteM=0, occ_o=0, and ready_e=1 after release.
- Streaming: ready_m=1 with bundles ALUResultE=0x10,0x20,0x30 on consecutive cycles. Required: ALUResultM shows 0x10,0x20,0x30 one cycle later each, with valid_m continuously 1.
- Stall, base mode: hold ready_m=0 for 3 cycles with bundle A held. Required: ready_e=0, M outputs stable at A, and the next EX bundle B appears only after ready_m=1.
- Stall, skid mode: with A held, set ready_m=0 and present B. Required: B is accepted, occ_o=2, ready_e=0 next cycle; after ready_m=1 the order is A then B.
- Flush mid-stall: hold A (plus B in skid mode) with MemWriteE=1, then assert flush_i=1 with bundle C on valid_e. Required: next cycle valid_m=0, MemWriteM=0, RegWriteM=0, occ_o=0; C is dropped.
- Reset during stall: with occ_o=2, assert rst_n=0 for 1 cycle. Required: all outputs 0 and the held bundles are lost.
